mdu_iterative: RTL and testbench

- Multi-cycle multiply/divide responder for the execute stage.
- Accepts the same FunctC/A/B request the combinational ALU select decodes. Serves only the Mul (1010) and Div (1111) codes, iteratively, and returns a 64-bit Hi/Lo result with a start/busy/done handshake.
- Sits beside the ALU. The control unit issues the request and stalls the pipeline on busy.

---
 rtl/mdu_iterative.sv | 156 +++++++++++++++
 tb/tb_mdu_iterative.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_iterative.sv
// rtl/mdu_iterative.sv - iterative signed multiply/divide responder (Mul 1010, Div 1111) with Hi/Lo result.
// Optional MDU_EARLY_OUT_EN: multiply leaves CALC once the remaining multiplier is zero.
module mdu_iterative #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       FunctC,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             DivByZero
);

  localparam logic [3:0] OP_MUL = 4'b1010;
  localparam logic [3:0] OP_DIV = 4'b1111;
`ifdef MDU_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     div_shift, div_trial;
  logic [2*WIDTH-1:0] prod;
  logic               last_iter;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;

    mag_a     = A[WIDTH-1] ? -A : A;
    mag_b     = B[WIDTH-1] ? -B : B;
    last_iter = (cnt_q == CNT_W'(WIDTH-1));
    // Partial remainder is one bit wider than the divisor so the trial borrow lands in the MSB.
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, mcand_q[WIDTH-1:0]};
    prod      = neg_res_q ? -acc_q : acc_q;

    case (state_q)
      S_IDLE: begin
        if (start && (FunctC == OP_MUL || FunctC == OP_DIV)) begin
          is_div_d  = (FunctC == OP_DIV);
          neg_res_d = A[WIDTH-1] ^ B[WIDTH-1];
          neg_rem_d = A[WIDTH-1];
          cnt_d     = '0;
          if (FunctC == OP_DIV) begin
            mcand_d = {{WIDTH{1'b0}}, mag_b};
            acc_d   = {{WIDTH{1'b0}}, mag_a};
          end else begin
            mcand_d  = {{WIDTH{1'b0}}, mag_a};
            mplier_d = mag_b;
            acc_d    = '0;
          end
          if (FunctC == OP_DIV && B == '0) begin
            state_d = S_DONE;
            hi_d    = A;
            lo_d    = '1;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!is_div_q) begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          if (last_iter || (EARLY_OUT && mplier_d == '0)) state_d = S_FIX;
        end else begin
          if (!div_trial[WIDTH]) acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else                   acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          if (last_iter) state_d = S_FIX;
        end
      end
      S_FIX: begin
        dbz_d   = 1'b0;
        state_d = S_DONE;
        if (!is_div_q) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else begin
          lo_d = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign Hi        = hi_q;
  assign Lo        = lo_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// tb/tb_mdu_iterative.sv - bench for mdu_iterative: arithmetic reference model, per-cycle compare, directed vectors.
module tb_mdu_iterative;
  localparam int W = 32;
  localparam logic [3:0] F_MUL = 4'b1010;
  localparam logic [3:0] F_DIV = 4'b1111;
`ifdef MDU_EARLY_OUT_EN
  localparam int LAT_M73 = 4;
  localparam int LAT_B1  = 3;
`else
  localparam int LAT_M73 = 34;
  localparam int LAT_B1  = 34;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   FunctC = 4'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy, done, DivByZero;
  logic [W-1:0] Hi, Lo;

  mdu_iterative #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .FunctC(FunctC), .A(A), .B(B),
    .busy(busy), .done(done), .Hi(Hi), .Lo(Lo), .DivByZero(DivByZero)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  bit          m_active = 1'b0;
  int          m_start_at = 0, m_done_at = 0, m_rst_at = -1, req_cyc = 0;
  logic [31:0] r_hi = '0, r_lo = '0;
  logic        r_dbz = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_dbz = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference: signed 64-bit arithmetic; SV division truncates toward zero and % follows the dividend.
  function automatic void model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo,
                                output logic dz, output int lat);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    lat = W + 2;
    if (f == F_MUL) begin
      p = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
`ifdef MDU_EARLY_OUT_EN
      begin
        longint mb;
        int k;
        mb = (sb < 0) ? -sb : sb;
        k = 0;
        while (mb != 0) begin k++; mb = mb >> 1; end
        if (k < 1) k = 1;
        lat = k + 2;
      end
`endif
    end else if (b == 32'd0) begin
      hi = a; lo = 32'hFFFF_FFFF; dz = 1'b1; lat = 1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      hi = r[31:0];
      lo = q[31:0];
    end
  endfunction

  function automatic bit abandoned();
    return m_rst_at > m_start_at && m_rst_at <= m_done_at;
  endfunction

  function automatic bit model_busy(input int c);
    return m_active && !abandoned() && c >= m_start_at && c <= m_done_at;
  endfunction

  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (cyc == m_rst_at) begin
      m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    end else if (m_active && !abandoned() && cyc == m_done_at) begin
      m_hi = r_hi; m_lo = r_lo; m_dbz = r_dbz;
    end
    chk("busy", 64'(busy), 64'(model_busy(cyc)));
    chk("done", 64'(done), 64'(m_active && !abandoned() && cyc == m_done_at));
    chk("hi", 64'(Hi), 64'(m_hi));
    chk("lo", 64'(Lo), 64'(m_lo));
    chk("dbz", 64'(DivByZero), 64'(m_dbz));
  end

  task automatic request(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] h, l;
    logic d;
    int lat, n;
    @(negedge clk);
    n = cyc;
    start = 1'b1; FunctC = f; A = a; B = b;
    if ((f == F_MUL || f == F_DIV) && !model_busy(n)) begin
      model(f, a, b, h, l, d, lat);
      r_hi = h; r_lo = l; r_dbz = d;
      m_start_at = n + 1;
      m_done_at = n + lat;
      m_active = 1'b1;
      req_cyc = n;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic expect_done(input string name, input int lat,
                             input logic [31:0] hi, input logic [31:0] lo, input logic dz);
    int k;
    for (k = 0; k < 60; k++) begin
      if (done === 1'b1) break;
      @(negedge clk);
    end
    if (k == 60) begin
      chk({name, "_timeout"}, 64'(0), 64'(1));
    end else begin
      chk({name, "_latency"}, 64'(cyc - req_cyc), 64'(lat));
      chk({name, "_hi"}, 64'(Hi), 64'(hi));
      chk({name, "_lo"}, 64'(Lo), 64'(lo));
      chk({name, "_dbz"}, 64'(DivByZero), 64'(dz));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_hilo", {Hi, Lo}, 64'(0));
    reset = 1'b0;

    request(F_MUL, 32'd30000, 32'd24672);
    expect_done("mul_basic", 34, 32'h0000_0000, 32'h2C1D_F200, 1'b0);
    request(F_MUL, 32'hFFFF_FFF9, 32'd3);
    expect_done("mul_neg", LAT_M73, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    request(F_DIV, 32'hFFFF_FFF9, 32'd2);
    expect_done("div_neg", 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    request(F_DIV, 32'd5, 32'd0);
    expect_done("div_zero", 1, 32'd5, 32'hFFFF_FFFF, 1'b1);
    request(F_DIV, 32'd100, 32'd7);
    expect_done("div_clear", 34, 32'd2, 32'd14, 1'b0);
    request(F_MUL, 32'h8000_0000, 32'h8000_0000);
    expect_done("mul_minmin", 34, 32'h4000_0000, 32'h0000_0000, 1'b0);
    request(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    expect_done("div_wrap", 34, 32'h0000_0000, 32'h8000_0000, 1'b0);
    request(F_MUL, 32'd12345, 32'd1);
    expect_done("mul_b1", LAT_B1, 32'd0, 32'd12345, 1'b0);
    request(F_DIV, 32'd7, 32'hFFFF_FFFE);
    expect_done("div_pos_neg", 34, 32'd1, 32'hFFFF_FFFD, 1'b0);
    request(F_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
    expect_done("div_neg_neg", 34, 32'hFFFF_FFFF, 32'd3, 1'b0);

    request(4'b0010, 32'd9, 32'd9);
    chk("bad_op_busy", 64'(busy), 64'(0));
    repeat (3) @(negedge clk);
    chk("bad_op_busy_later", 64'(busy), 64'(0));

    request(F_MUL, 32'd6, 32'd7);
    repeat (5) @(negedge clk);
    request(F_MUL, 32'd100, 32'd100);
    expect_done("mul_ignore", 34, 32'd0, 32'd42, 1'b0);

    request(F_DIV, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    m_rst_at = cyc + 1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_busy", 64'(busy), 64'(0));
    chk("rst_mid_done", 64'(done), 64'(0));
    chk("rst_mid_hilo", {Hi, Lo}, 64'(0));
    repeat (40) @(negedge clk);
    request(F_DIV, 32'd1000, 32'd3);
    expect_done("div_after_rst", 34, 32'd1, 32'd333, 1'b0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
